// File: rtl/pgm_pkg.sv
// Shared types and constants for the PGM replay scheduler.
// State encoding, word tags, config register offsets and the tag helper.
package pgm_pkg;

    localparam int PGM_ADDR_W = 7;
    localparam int PGM_GAP_W  = 16;
    localparam int RAM_W      = 144;
    localparam int PAY_W      = 132;
    localparam int OUT_W      = 134;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_READ,
        ST_DRAIN,
        ST_GAP
    } state_t;

    localparam logic [1:0] TAG_HDR  = 2'b01;
    localparam logic [1:0] TAG_MID  = 2'b11;
    localparam logic [1:0] TAG_TAIL = 2'b10;

    localparam logic [1:0] CFG_PKT_NUM = 2'd0;
    localparam logic [1:0] CFG_GAP     = 2'd1;
    localparam logic [1:0] CFG_CTRL    = 2'd2;

    // First word wins if both are flagged; a template always has
    // at least two words, so that only happens on idle cycles.
    function automatic logic [1:0] tag_of(
        input logic i_first,
        input logic i_last
    );
        logic [1:0] w_t;
        if (i_first)
            w_t = TAG_HDR;
        else if (i_last)
            w_t = TAG_TAIL;
        else
            w_t = TAG_MID;
        return w_t;
    endfunction

endpackage

// File: rtl/pgm_gap_timer.sv
// Inter-packet pacing counter: load a gap, count it down, flag expiry.
// Ports: clk, rst_n, i_load/i_val (load), i_count (enable), o_expire.
module pgm_gap_timer
    import pgm_pkg::*;
#(
    parameter int GAP_W = PGM_GAP_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [GAP_W-1:0] i_val,
    input  logic             i_count,
    output logic             o_expire
);

    logic [GAP_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_val;
        else if (i_count && r_cnt != '0)
            r_cnt <= r_cnt - GAP_W'(1);
    end

    // Expires on the last counting cycle so a gap of N spends exactly
    // N cycles in the counting state.
    assign o_expire = i_count && (r_cnt <= GAP_W'(1));

endmodule

// File: rtl/pgm_sched.sv
// Replay scheduler: re-reads the stored template from PGM_RAM and emits
// it N times (or forever), paced by a gap, yielding to bypass/almost-full.
// Ports: cfg_* register bus, start/last_addr, rd_* RAM port,
// out_* packet stream, busy/done/sent_cnt status.
module pgm_sched
    import pgm_pkg::*;
#(
    parameter int ADDR_W = PGM_ADDR_W,
    parameter int GAP_W  = PGM_GAP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] last_addr,
    input  logic              bypass_busy,
    input  logic              cfg_wr,
    input  logic [1:0]        cfg_addr,
    input  logic [31:0]       cfg_wdata,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [RAM_W-1:0]  rd_data,
    input  logic              in_alf,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_data_wr,
    output logic              out_valid,
    output logic              out_valid_wr,
    output logic              busy,
    output logic              done,
    output logic [31:0]       sent_cnt
);

    state_t             r_state;
    logic [31:0]        r_pkt_num;
    logic [GAP_W-1:0]   r_gap;
    logic               r_enable;
    logic [ADDR_W-1:0]  r_last;
    logic               r_rd_en;
    logic [ADDR_W-1:0]  r_rd_addr;
    logic               r_rd_v;
    logic [ADDR_W-1:0]  r_rd_a;
    logic [OUT_W-1:0]   r_out_data;
    logic               r_out_wr;
    logic               r_out_last;
    logic               r_done;
    logic [31:0]        r_sent;

    logic               w_gap_expire;
    logic               w_is_first;
    logic               w_is_last;
    logic [31:0]        w_sent_nxt;
    logic               w_unused;

    assign w_unused   = ^{rd_data[RAM_W-1:PAY_W], cfg_wdata};
    assign w_is_first = (r_rd_a == '0);
    assign w_is_last  = (r_rd_a == r_last);
    assign w_sent_nxt = r_sent + 32'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pkt_num <= '0;
            r_gap     <= '0;
            r_enable  <= 1'b0;
        end else if (cfg_wr) begin
            case (cfg_addr)
                CFG_PKT_NUM: r_pkt_num <= cfg_wdata;
                CFG_GAP:     r_gap     <= cfg_wdata[GAP_W-1:0];
                CFG_CTRL:    r_enable  <= cfg_wdata[0];
                default:     ;
            endcase
        end
    end

    pgm_gap_timer #(
        .GAP_W (GAP_W)
    ) u_gap (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (r_state == ST_DRAIN),
        .i_val    (r_gap),
        .i_count  (r_state == ST_GAP),
        .o_expire (w_gap_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_last     <= '0;
            r_rd_en    <= 1'b0;
            r_rd_addr  <= '0;
            r_rd_v     <= 1'b0;
            r_rd_a     <= '0;
            r_out_data <= '0;
            r_out_wr   <= 1'b0;
            r_out_last <= 1'b0;
            r_done     <= 1'b0;
            r_sent     <= '0;
        end else begin
            // RAM returns data one cycle after rd_en; track the
            // address alongside so the tag lines up with the word.
            r_done     <= 1'b0;
            r_rd_v     <= r_rd_en;
            r_rd_a     <= r_rd_addr;
            r_out_wr   <= r_rd_v;
            r_out_last <= r_rd_v && w_is_last;
            if (r_rd_v)
                r_out_data <= {tag_of(w_is_first, w_is_last),
                               rd_data[PAY_W-1:0]};

            unique case (r_state)
                ST_IDLE: begin
                    if (start && r_enable && last_addr != '0) begin
                        r_last  <= last_addr;
                        r_sent  <= '0;
                        r_state <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (!bypass_busy && !in_alf) begin
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= '0;
                        r_state   <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (r_rd_addr == r_last) begin
                        r_rd_en <= 1'b0;
                        r_state <= ST_DRAIN;
                    end else begin
                        r_rd_addr <= r_rd_addr + ADDR_W'(1);
                    end
                end
                ST_DRAIN: begin
                    // This edge registers the tail word out.
                    r_sent <= w_sent_nxt;
                    if (!r_enable) begin
                        r_state <= ST_IDLE;
                    end else if (r_pkt_num != '0 &&
                                 w_sent_nxt == r_pkt_num) begin
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end else if (r_gap == '0) begin
                        r_state <= ST_ARM;
                    end else begin
                        r_state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (w_gap_expire)
                        r_state <= ST_ARM;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rd_en        = r_rd_en;
    assign rd_addr      = r_rd_addr;
    assign out_data     = r_out_data;
    assign out_data_wr  = r_out_wr;
    assign out_valid    = r_out_last;
    assign out_valid_wr = r_out_last;
    assign busy         = (r_state != ST_IDLE);
    assign done         = r_done;
    assign sent_cnt     = r_sent;

endmodule

// File: tb/tb_pgm_sched.sv
// Self-checking bench for pgm_sched: RAM model plus expected-word queue.
// Covers counted runs, ARM stalls, graceful stop, ignored starts, reset.
module tb_pgm_sched;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [6:0]   last_addr = '0;
    logic         bypass_busy = 1'b0;
    logic         cfg_wr = 1'b0;
    logic [1:0]   cfg_addr = '0;
    logic [31:0]  cfg_wdata = '0;
    logic         rd_en;
    logic [6:0]   rd_addr;
    logic [143:0] rd_data = '0;
    logic         in_alf = 1'b0;
    logic [133:0] out_data;
    logic         out_data_wr;
    logic         out_valid;
    logic         out_valid_wr;
    logic         busy;
    logic         done;
    logic [31:0]  sent_cnt;

    pgm_sched dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .last_addr    (last_addr),
        .bypass_busy  (bypass_busy),
        .cfg_wr       (cfg_wr),
        .cfg_addr     (cfg_addr),
        .cfg_wdata    (cfg_wdata),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .in_alf       (in_alf),
        .out_data     (out_data),
        .out_data_wr  (out_data_wr),
        .out_valid    (out_valid),
        .out_valid_wr (out_valid_wr),
        .busy         (busy),
        .done         (done),
        .sent_cnt     (sent_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [133:0] d;
        logic         last;
    } exp_t;

    exp_t         q[$];
    logic [143:0] mem [128];
    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int n_rd = 0;
    int n_words = 0;
    int n_done = 0;
    int exp_idle = -1;
    int last_cyc = -1;
    int first_cyc = -1;
    logic p_last = 1'b1;

    task automatic chk(input string tag,
                       input logic [133:0] got,
                       input logic [133:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_en)
            rd_data <= mem[rd_addr];
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            p_last = 1'b1;
        end else begin
            if (rd_en)
                n_rd++;
            if (done) begin
                n_done++;
                chk("done_with_tail", out_valid_wr, 1);
            end
            if (!p_last)
                chk("contig", out_data_wr, 1);
            if (out_data_wr) begin
                n_words++;
                if (p_last) begin
                    if (exp_idle >= 0 && last_cyc >= 0)
                        chk("idle_gap", cyc - last_cyc - 1, exp_idle);
                    if (first_cyc < 0)
                        first_cyc = cyc;
                end
                if (q.size() == 0) begin
                    chk("spurious_word", out_data_wr, 0);
                end else begin
                    e = q.pop_front();
                    chk("word", out_data, e.d);
                    chk("last_flags", {out_valid, out_valid_wr},
                        {e.last, e.last});
                end
                if (out_valid)
                    last_cyc = cyc;
                p_last = out_valid;
            end
        end
    end

    task automatic cfg(input logic [1:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        cfg_wr = 1'b1;
        cfg_addr = a;
        cfg_wdata = d;
        @(posedge clk); #1;
        cfg_wr = 1'b0;
    endtask

    task automatic start_pkt(input logic [6:0] la, output int s);
        @(posedge clk); #1;
        last_addr = la;
        start = 1'b1;
        s = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic push_pkts(input int la, input int n);
        exp_t e;
        logic [1:0] t;
        for (int p = 0; p < n; p++) begin
            for (int a = 0; a <= la; a++) begin
                t = (a == 0) ? 2'b01 : ((a == la) ? 2'b10 : 2'b11);
                e.d = {t, mem[a][131:0]};
                e.last = (a == la);
                q.push_back(e);
            end
        end
    endtask

    task automatic wait_idle(input string tag, input int max);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (busy && k < max);
        chk(tag, busy, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_words(input string tag, input int target,
                              input int max);
        int k = 0;
        while (n_words < target && k < max) begin
            @(negedge clk);
            k++;
        end
        chk(tag, n_words >= target, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s, d0, r0, w0, dd;
        for (int i = 0; i < 128; i++)
            mem[i] = {16'($urandom), $urandom, $urandom,
                      $urandom, $urandom};

        repeat (3) @(posedge clk); #1;
        chk("rst_ctrl", {rd_en, out_data_wr, out_valid,
                         out_valid_wr, busy, done}, 0);
        chk("rst_data", out_data, 0);
        chk("rst_addr", rd_addr, 0);
        chk("rst_cnt", sent_cnt, 0);
        rst_n = 1'b1;

        // counted run, 2 packets, gap 5
        cfg(2'd0, 2);
        cfg(2'd1, 5);
        cfg(2'd2, 1);
        push_pkts(3, 2);
        exp_idle = 7;
        last_cyc = -1;
        first_cyc = -1;
        d0 = n_done;
        start_pkt(7'd3, s);
        wait_idle("t1_timeout", 200);
        chk("t1_first_lat", first_cyc - s, 4);
        chk("t1_sent", sent_cnt, 2);
        chk("t1_done", n_done - d0, 1);
        chk("t1_q", q.size(), 0);

        // ARM held by almost-full
        cfg(2'd0, 1);
        exp_idle = -1;
        first_cyc = -1;
        @(posedge clk); #1;
        in_alf = 1'b1;
        push_pkts(5, 1);
        start_pkt(7'd5, s);
        r0 = n_rd;
        repeat (10) @(posedge clk); #1;
        chk("t2_busy", busy, 1);
        chk("t2_no_rd", n_rd - r0, 0);
        in_alf = 1'b0;
        dd = cyc;
        wait_idle("t2_timeout", 200);
        chk("t2_lat", first_cyc - dd, 3);
        chk("t2_sent", sent_cnt, 1);
        chk("t2_q", q.size(), 0);

        // bypass raised mid-packet
        cfg(2'd0, 2);
        cfg(2'd1, 0);
        push_pkts(9, 2);
        w0 = n_words;
        start_pkt(7'd9, s);
        wait_words("t3_first", w0 + 1, 50);
        @(posedge clk); #1;
        bypass_busy = 1'b1;
        repeat (20) @(posedge clk); #1;
        chk("t3_held_words", n_words - w0, 10);
        chk("t3_held_busy", busy, 1);
        bypass_busy = 1'b0;
        wait_idle("t3_timeout", 200);
        chk("t3_words", n_words - w0, 20);
        chk("t3_sent", sent_cnt, 2);
        chk("t3_q", q.size(), 0);

        // continuous run, graceful stop in packet 5
        cfg(2'd0, 0);
        cfg(2'd1, 2);
        exp_idle = 4;
        last_cyc = -1;
        push_pkts(7, 5);
        w0 = n_words;
        d0 = n_done;
        start_pkt(7'd7, s);
        wait_words("t4_reach", w0 + 4 * 8 + 3, 1000);
        cfg(2'd2, 0);
        wait_idle("t4_timeout", 200);
        chk("t4_sent", sent_cnt, 5);
        chk("t4_no_done", n_done - d0, 0);
        chk("t4_q", q.size(), 0);
        exp_idle = -1;

        // ignored starts
        cfg(2'd2, 1);
        cfg(2'd0, 1);
        r0 = n_rd;
        start_pkt(7'd0, s);
        repeat (5) @(posedge clk); #1;
        chk("t5_zero_busy", busy, 0);
        cfg(2'd2, 0);
        start_pkt(7'd3, s);
        repeat (5) @(posedge clk); #1;
        chk("t5_dis_busy", busy, 0);
        chk("t5_no_rd", n_rd - r0, 0);
        cfg(2'd2, 1);
        push_pkts(5, 1);
        d0 = n_done;
        start_pkt(7'd5, s);
        @(posedge clk); #1;
        chk("t5_in_read", rd_en, 1);
        start_pkt(7'd2, s);
        wait_idle("t5_timeout", 200);
        chk("t5_sent", sent_cnt, 1);
        chk("t5_done", n_done - d0, 1);
        chk("t5_q", q.size(), 0);

        // reset mid-packet
        cfg(2'd0, 0);
        cfg(2'd1, 3);
        push_pkts(6, 3);
        w0 = n_words;
        start_pkt(7'd6, s);
        wait_words("t6_first", w0 + 1, 50);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("t6_ctrl", {rd_en, out_data_wr, out_valid,
                        out_valid_wr, busy, done}, 0);
        chk("t6_data", out_data, 0);
        chk("t6_addr", rd_addr, 0);
        chk("t6_cnt", sent_cnt, 0);
        q.delete();
        repeat (2) @(posedge clk); #3;
        rst_n = 1'b1;
        r0 = n_rd;
        start_pkt(7'd3, s);
        repeat (5) @(posedge clk); #1;
        chk("t6_en_default", busy, 0);
        chk("t6_no_rd", n_rd - r0, 0);
        cfg(2'd2, 1);
        cfg(2'd0, 2);
        exp_idle = 2;
        last_cyc = -1;
        push_pkts(3, 2);
        start_pkt(7'd3, s);
        wait_idle("t6_timeout", 200);
        chk("t6_sent", sent_cnt, 2);
        chk("t6_q", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/pgm_sched.md
# pgm_sched

Replay scheduler for the PGM packet generator. After a template packet has been stored in PGM_RAM, it re-reads the RAM and emits the stored packet N times (or continuously) on the generator output. Packets are paced by a programmable inter-packet gap. The block arbitrates the shared output against bypass traffic and honours downstream almost-full. It sits between PGM_RAM's read port and the pgm output toward DMID.

## Interface
- ADDR_W, 7, PGM_RAM address width (128 words max per packet)
- GAP_W, 16, inter-packet gap counter width
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse: template stored, replay may begin
- last_addr  in  ADDR_W  address of the template's final word; sampled on start
- bypass_busy  in  1  high while bypass traffic owns the output
- cfg_wr  in  1  register write strobe
- cfg_addr  in  2  register select: 0 pkt_num[31:0] (0 = continuous); 1 gap[GAP_W-1:0]; 2 ctrl, bit0 enable
- cfg_wdata  in  32  register write data
- rd_en  out  1  PGM_RAM read enable
- rd_addr  out  ADDR_W  PGM_RAM read address
- rd_data  in  144  PGM_RAM read data; valid one cycle after rd_en
- in_alf  in  1  downstream almost-full
- out_data  out  134  packet word
- out_data_wr  out  1  word strobe
- out_valid  out  1  packet valid flag, 1 on the last word
- out_valid_wr  out  1  valid strobe, pulses with the last word
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse when the programmed count completes
- sent_cnt  out  32  packets emitted in the current run

## Operation
- Reset values:
  - All outputs are 0.
  - pkt_num = 0, gap = 0, enable = 0; state IDLE.
- IDLE:
  - start with enable = 1 and last_addr ≥ 1: latch last_addr, clear sent_cnt, go to ARM.
  - start while enable = 0, while last_addr = 0, or outside IDLE is ignored.
- ARM: stay while bypass_busy = 1 or in_alf = 1; otherwise go to READ with rd_addr = 0.
- READ:
  - rd_en = 1 every cycle; rd_addr increments by 1.
  - On the cycle rd_addr == latched last_addr, go to DRAIN.
  - A started packet always runs to completion. in_alf and bypass_busy are ignored mid-packet; downstream headroom of at least 128 words is required.
- DRAIN: wait one cycle for the final RAM word, then register it out.
- Output word (registered): out_data = {tag, rd_data[131:0]}, where the tag is forced as follows:
  - 01 for address 0
  - 10 for last_addr
  - 11 for all other addresses
- Last-word handling: out_valid = 1 and out_valid_wr = 1 on the last word; sent_cnt increments on the same edge.
- After the last word:
  - If enable = 0, go to IDLE (graceful stop).
  - Else if pkt_num ≠ 0 and the new sent_cnt == pkt_num, pulse done and go to IDLE.
  - Else go to GAP.
- GAP: count gap idle cycles, then go to ARM. gap = 0 goes directly to ARM.
- Configuration:
  - cfg writes take effect on the next edge in any state.
  - gap and pkt_num are sampled at each use.
  - Writing pkt_num at or below the current sent_cnt mid-run makes the run continuous until the 32-bit wrap.
- sent_cnt wraps modulo 2^32 silently in continuous mode.

## Timing
- Latency: the word for rd_addr issued at cycle t appears on out_data at t+2.
- First-word latency: start to ARM is 1 cycle; ARM to READ is at least 1 cycle. With no stall, the first out_data_wr occurs 4 cycles after start.
- Per packet:
  - out_data_wr stays high for exactly last_addr+1 contiguous cycles.
  - Consecutive packets are separated by gap + 2 or more idle output cycles (the ARM check adds 1 cycle).
- done, out_valid_wr and the sent_cnt update share one edge.
- in_alf and bypass_busy are sampled only in ARM. Both must be low in the same cycle to leave ARM.
- Reset mid-packet aborts immediately with all outputs 0. No partial packet is completed.

## Structure
- Shared package pgm_pkg:
  - state encoding (IDLE, ARM, READ, DRAIN, GAP)
  - tag constants HDR = 2'b01, MID = 2'b11, TAIL = 2'b10
  - cfg register offsets
  - ADDR_W default
- Sub-module pgm_gap_timer (load, count, expire) isolates the pacing counter. Everything else is a single FSM plus the output register stage.

## Test plan
- Packet count: last_addr = 3, pkt_num = 2, gap = 5, enable = 1, start pulse. Required response:
  - two 4-word bursts tagged 01, 11, 11, 10
  - 7 idle output cycles between the bursts
  - done pulses with the second tail; sent_cnt = 2; busy then falls
- ARM hold: in_alf held 1 from before start for 10 cycles. No rd_en during those cycles; first out_data_wr 3 cycles after in_alf drops.
- Mid-packet stall inputs: bypass_busy raised mid-packet (last_addr = 9). All 10 words are emitted contiguously; the next packet is held in ARM until bypass_busy drops.
- Graceful stop: continuous mode (pkt_num = 0); enable written 0 during word 2 of packet 5. Packet 5 completes; IDLE follows; sent_cnt = 5; no done pulse.
- Ignored starts: start with last_addr = 0, or with enable = 0, leaves busy at 0 and no rd_en; start pulsed during READ is ignored.
- Reset mid-packet: rst_n asserted during READ. All outputs are 0 immediately; the registers read back defaults (gap = 0, enable = 0).
